imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the decode-side immediate extractor. Takes a 32-bit sign-extended immediate, a format code and a base instruction word, and packs the immediate into the format-specific RV32I bit positions.
- Used by the debug/instruction-injection path to build legal instruction words. Also used as a round-trip checker against the decoder.
- Two-stage valid/ready pipeline with range checking, error flagging and saturating statistics counters.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters.

Ports:
- cpu_clk  in  1  clock. All state updates on the rising edge.
- cpu_rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input request valid.
- in_ready  out  1  input can be accepted this cycle.
- in_fmt  in  3  format code: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J. 110 and 111 are illegal.
- in_imm  in  32  sign-extended immediate value, in the same form the decoder produces.
- in_base  in  32  instruction word carrying opcode, rd, rs1, rs2 and funct fields. Its immediate bit positions are ignored.
- out_valid  out  1  encoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_inst  out  32  encoded instruction word.
- out_err  out  1  the immediate was out of range or misaligned, or the format was illegal.
- enc_cnt  out  CNT_W  count of results accepted downstream, saturating.
- err_cnt  out  CNT_W  count of accepted results with out_err=1, saturating.

Behaviour:
- Reset state: out_valid=0, out_inst=0, out_err=0, enc_cnt=0, err_cnt=0, both stage-valid flags cleared. in_ready=1 once cpu_rst deasserts.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.

Stage 1 (S1), registered:
- Captures fmt, imm and base.
- Computes err1 (range check) and mask1 (immediate bit positions).

Range checks, using signed in_imm:
- I and S: -2048 ≤ imm ≤ 2047.
- B: imm[0]=0 and -4096 ≤ imm ≤ 4094.
- J: imm[0]=0 and -1048576 ≤ imm ≤ 1048574.
- U: imm[11:0]=0. All values of imm[31:12] are accepted.
- 000: always legal; imm is ignored.
- 110 and 111: always err.

Immediate masks:
- I: bits [31:20].
- S and B: bits [31:25] and [11:7].
- U and J: bits [31:12].
- 000, 110, 111: no bits.

Stage 2 (S2), registered:
- out_inst = (base & ~mask) | packed.
- packed, per format:
  - I: imm[11:0] → [31:20].
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B: imm[12] → 31, imm[10:5] → [30:25], imm[4:1] → [11:8], imm[11] → 7.
  - U: imm[31:12] → [31:12].
  - J: imm[20] → 31, imm[10:1] → [30:21], imm[11] → 20, imm[19:12] → [19:12].
- On err: packed=0, so the immediate field is cleared and the other base fields pass through. out_err=1.

Pipeline flow:
- Latency is 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- S2 loads when S2 is empty or is transferring this cycle.
- S1 advances into S2 under the same condition.
- in_ready = !s1_valid || s1_advances. This is a combinational ready chain; no skid buffer.
- While out_valid=1 && out_ready=0, out_inst and out_err stay stable.
- Simultaneous input and output transfer in the same cycle: both occur and no bubble is inserted.

Counters:
- On each output transfer, enc_cnt += 1 and err_cnt += out_err.
- Both hold at 2^CNT_W - 1 and do not wrap.

Reset and correctness:
- Reset mid-operation discards all in-flight entries immediately. Counters clear.
- Round-trip invariant: for every legal input, decoder(out_inst, fmt) == in_imm, and out_inst & ~mask == in_base & ~mask.

Decomposition:
- Shared package: format code constants FMT_NONE..FMT_J (matching the decoder's select encoding) and the per-format range limit constants.
- One natural sub-module, imm_range_chk: combinational err and mask from fmt and imm. It is instantiated in S1.
- Packing and pipeline control live in imm_encoder.

Test Plan:
- I-type: fmt=001, base=0x00000093, imm=0xFFFFFFFF → out_inst=0xFFF00093, err=0, out_valid exactly 2 cycles after accept.
- S/B-type:
  - S: fmt=010, base=0x0020A023, imm=8 → 0x0020A423.
  - B: fmt=011, base=0x00000063, imm=0xFFFFFFFC → 0xFE000EE3.
- U/J-type:
  - U: fmt=100, base=0x000002B7, imm=0x12345000 → 0x123452B7.
  - J: fmt=101, base=0x000000EF, imm=0x800 → 0x001000EF.
- Errors:
  - fmt=001, base=0xABC00093, imm=2048 → out_inst=0x00000093, err=1, err_cnt increments.
  - fmt=011, imm=3 → err=1.
  - fmt=111 → err=1.
- Backpressure: stream 4 back-to-back I-type inputs, imm 1..4, holding out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts and out_inst holds stable.
  - On release, all 4 results emerge in order with no loss or duplication; enc_cnt=4.
- Reset and saturation:
  - Assert cpu_rst with both stages full → out_valid=0 on the same edge; in_ready=1 after deassertion; counters=0.
  - Separately, with CNT_W=2, 5 transfers → enc_cnt=3.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV32I immediate encoder.
// Format codes match the decode-side immediate select encoding; range
// limits are the signed bounds each format can represent.
package imm_encoder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FMT_W  = 3;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'b000;
  localparam logic [FMT_W-1:0] FMT_I    = 3'b001;
  localparam logic [FMT_W-1:0] FMT_S    = 3'b010;
  localparam logic [FMT_W-1:0] FMT_B    = 3'b011;
  localparam logic [FMT_W-1:0] FMT_U    = 3'b100;
  localparam logic [FMT_W-1:0] FMT_J    = 3'b101;

  // Signed range limits (inclusive).
  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -1048576;
  localparam int J_MAX  = 1048574;

  // Immediate bit-position masks within the instruction word.
  localparam logic [DATA_W-1:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [DATA_W-1:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [DATA_W-1:0] MASK_UJ = 32'hFFFF_F000;

endpackage

// File: rtl/imm_range_chk.sv
// Combinational range/alignment check and immediate-field mask lookup.
// Ports:
//   i_fmt  - format code
//   i_imm  - sign-extended immediate
//   o_err  - immediate unrepresentable in this format, or illegal format
//   o_mask - instruction bit positions owned by the immediate
module imm_range_chk
  import imm_encoder_pkg::*;
(
  input  logic [FMT_W-1:0]  i_fmt,
  input  logic [DATA_W-1:0] i_imm,
  output logic              o_err,
  output logic [DATA_W-1:0] o_mask
);

  logic signed [DATA_W-1:0] w_simm;
  assign w_simm = $signed(i_imm);

  always_comb begin
    o_err  = 1'b0;
    o_mask = '0;
    unique case (i_fmt)
      FMT_NONE: begin
        o_err  = 1'b0;
        o_mask = '0;
      end
      FMT_I: begin
        o_err  = (w_simm < IS_MIN) || (w_simm > IS_MAX);
        o_mask = MASK_I;
      end
      FMT_S: begin
        o_err  = (w_simm < IS_MIN) || (w_simm > IS_MAX);
        o_mask = MASK_SB;
      end
      FMT_B: begin
        o_err  = i_imm[0] || (w_simm < B_MIN) || (w_simm > B_MAX);
        o_mask = MASK_SB;
      end
      FMT_U: begin
        o_err  = (i_imm[11:0] != 12'h000);
        o_mask = MASK_UJ;
      end
      FMT_J: begin
        o_err  = i_imm[0] || (w_simm < J_MIN) || (w_simm > J_MAX);
        o_mask = MASK_UJ;
      end
      default: begin
        o_err  = 1'b1;
        o_mask = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32I immediate encoder.
// S1 registers the request with its range error and field mask; S2 packs
// the immediate into the base word and presents the result.
// Ports:
//   cpu_clk, cpu_rst               - clock, async active-high reset
//   in_valid/in_ready              - request handshake (ready is combinational)
//   in_fmt, in_imm, in_base        - format, sign-extended immediate, base word
//   out_valid/out_ready            - result handshake
//   out_inst, out_err              - encoded word and error flag
//   enc_cnt, err_cnt               - saturating result / error counters
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  in_fmt,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic              out_err,
  output logic [CNT_W-1:0]  enc_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Scatter immediate bits into their format-specific positions.
  function automatic logic [DATA_W-1:0] pack_imm(input logic [FMT_W-1:0] fmt,
                                                 input logic [DATA_W-1:0] imm);
    logic [DATA_W-1:0] p;
    p = '0;
    unique case (fmt)
      FMT_I: p[31:20] = imm[11:0];
      FMT_S: begin
        p[31:25] = imm[11:5];
        p[11:7]  = imm[4:0];
      end
      FMT_B: begin
        p[31]    = imm[12];
        p[30:25] = imm[10:5];
        p[11:8]  = imm[4:1];
        p[7]     = imm[11];
      end
      FMT_U: p[31:12] = imm[31:12];
      FMT_J: begin
        p[31]    = imm[20];
        p[30:21] = imm[10:1];
        p[20]    = imm[11];
        p[19:12] = imm[19:12];
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  logic              r_s1_valid;
  logic [FMT_W-1:0]  r_s1_fmt;
  logic [DATA_W-1:0] r_s1_imm;
  logic [DATA_W-1:0] r_s1_base;
  logic              r_s1_err;
  logic [DATA_W-1:0] r_s1_mask;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_inst;
  logic              r_out_err;
  logic [CNT_W-1:0]  r_enc_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_err1;
  logic [DATA_W-1:0] w_mask1;
  logic              w_out_fire;
  logic              w_s2_load;
  logic              w_s1_adv;
  logic [DATA_W-1:0] w_packed;
  logic [DATA_W-1:0] w_s2_inst;

  imm_range_chk u_range_chk (
    .i_fmt  (in_fmt),
    .i_imm  (in_imm),
    .o_err  (w_err1),
    .o_mask (w_mask1)
  );

  // Ready chain: S2 frees when empty or draining; S1 frees when it moves on.
  assign w_out_fire = r_out_valid && out_ready;
  assign w_s2_load  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign in_ready   = !r_s1_valid || w_s1_adv;

  // Erroneous requests clear the immediate field but keep other base fields.
  assign w_packed  = r_s1_err ? '0 : pack_imm(r_s1_fmt, r_s1_imm);
  assign w_s2_inst = (r_s1_base & ~r_s1_mask) | w_packed;

  // Stage 1 capture.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= '0;
      r_s1_imm   <= '0;
      r_s1_base  <= '0;
      r_s1_err   <= 1'b0;
      r_s1_mask  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_fmt  <= in_fmt;
        r_s1_imm  <= in_imm;
        r_s1_base <= in_base;
        r_s1_err  <= w_err1;
        r_s1_mask <= w_mask1;
      end
    end
  end

  // Stage 2 output register; holds while stalled.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_inst <= w_s2_inst;
        r_out_err  <= r_s1_err;
      end
    end
  end

  // Saturating statistics on output transfers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_enc_cnt != CNT_MAX) r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (r_out_err && (r_err_cnt != CNT_MAX)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_err   = r_out_err;
  assign enc_cnt   = r_enc_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: per-format vectors,
// range errors, backpressure ordering, mid-flight reset and counter saturation.
module tb_imm_encoder;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [2:0]  s_in_fmt;
  logic [31:0] s_in_imm;
  logic [31:0] s_in_base;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_inst;
  logic        s_out_err;
  logic [1:0]  s_enc_cnt;
  logic [1:0]  s_err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_enc  = 0;
  int exp_err  = 0;

  imm_encoder #(.CNT_W(16)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_cnt   (enc_cnt),
    .err_cnt   (err_cnt)
  );

  imm_encoder #(.CNT_W(2)) dut_sat (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_fmt    (s_in_fmt),
    .in_imm    (s_in_imm),
    .in_base   (s_in_base),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_inst  (s_out_inst),
    .out_err   (s_out_err),
    .enc_cnt   (s_enc_cnt),
    .err_cnt   (s_err_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_enc = 0;
    exp_err = 0;
  endtask

  // One request with no backpressure: checks 2-cycle latency, result, counters.
  task automatic run_one(input string tag, input logic [2:0] f, input logic [31:0] imm,
                         input logic [31:0] base, input logic [31:0] ei, input logic ee);
    @(negedge cpu_clk);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_imm    = imm;
    in_base   = base;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge cpu_clk);
    #1;
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_inst"}, out_inst, ei);
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
    @(posedge cpu_clk);
    #1;
    exp_enc++;
    if (ee) exp_err++;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    chk({tag, "_enc"}, 32'(enc_cnt), 32'(exp_enc));
    chk({tag, "_errc"}, 32'(err_cnt), 32'(exp_err));
  endtask

  logic [31:0] bp_exp [4];
  int          send_idx;
  int          recv_idx;
  logic        acc_in;
  logic        acc_out;

  initial begin
    cpu_rst     = 1'b1;
    in_valid    = 1'b0;
    in_fmt      = 3'b000;
    in_imm      = '0;
    in_base     = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_fmt    = 3'b111;
    s_in_imm    = 32'd5;
    s_in_base   = 32'h0000_0013;
    s_out_ready = 1'b1;
    repeat (3) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Per-format vectors and boundaries.
    run_one("i_neg1",  3'b001, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    run_one("s_8",     3'b010, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
    run_one("b_m4",    3'b011, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    run_one("u_val",   3'b100, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    run_one("j_800",   3'b101, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    run_one("i_min",   3'b001, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    run_one("b_max",   3'b011, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    run_one("j_min",   3'b101, 32'hFFF0_0000, 32'h0000_00EF, 32'h8000_00EF, 1'b0);
    run_one("none",    3'b000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    // Error cases: immediate field cleared, other fields kept.
    run_one("e_i2048", 3'b001, 32'h0000_0800, 32'hABC0_0093, 32'h0000_0093, 1'b1);
    run_one("e_b3",    3'b011, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1);
    run_one("e_b4096", 3'b011, 32'h0000_1000, 32'h0000_0063, 32'h0000_0063, 1'b1);
    run_one("e_u_low", 3'b100, 32'h1234_5001, 32'h0000_02B7, 32'h0000_02B7, 1'b1);
    run_one("e_fmt7",  3'b111, 32'h0000_0005, 32'h1234_5678, 32'h1234_5678, 1'b1);

    // Reset with both stages full.
    @(negedge cpu_clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_fmt    = 3'b001;
    in_imm    = 32'd7;
    in_base   = 32'h0000_0093;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    in_imm = 32'd9;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cpu_rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_enc = 0;
    exp_err = 0;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge cpu_clk);
    #1;
    chk("mrst_flushed", 32'(out_valid), 32'd0);

    // Backpressure: 4 back-to-back requests, output stalled for 3 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) bp_exp[k] = (32'(k + 1) << 20) | 32'h0000_0093;
    send_idx = 0;
    recv_idx = 0;
    for (int cyc = 0; cyc < 40 && recv_idx < 4; cyc++) begin
      @(negedge cpu_clk);
      in_valid  = (send_idx < 4);
      in_fmt    = 3'b001;
      in_imm    = 32'(send_idx + 1);
      in_base   = 32'h0000_0093;
      out_ready = (cyc >= 5);
      #1;
      if (cyc < 2) chk("bp_rdy_early", 32'(in_ready), 32'd1);
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp_rdy_drop", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_inst", out_inst, bp_exp[0]);
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        chk("bp_order", out_inst, bp_exp[recv_idx]);
        chk("bp_err", 32'(out_err), 32'd0);
        recv_idx++;
      end
      @(posedge cpu_clk);
      if (acc_in) send_idx++;
    end
    in_valid = 1'b0;
    chk("bp_recv_count", 32'(recv_idx), 32'd4);
    @(negedge cpu_clk);
    chk("bp_enc_cnt", 32'(enc_cnt), 32'd4);
    chk("bp_err_cnt", 32'(err_cnt), 32'd0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Saturation on the 2-bit counter instance (all requests illegal format).
    @(negedge cpu_clk);
    s_in_valid = 1'b1;
    repeat (3) @(negedge cpu_clk);
    s_in_valid = 1'b0;
    repeat (4) @(negedge cpu_clk);
    chk("sat_enc_3", 32'(s_enc_cnt), 32'd3);
    chk("sat_err_3", 32'(s_err_cnt), 32'd3);
    s_in_valid = 1'b1;
    repeat (2) @(negedge cpu_clk);
    s_in_valid = 1'b0;
    repeat (4) @(negedge cpu_clk);
    chk("sat_enc_5", 32'(s_enc_cnt), 32'd3);
    chk("sat_err_5", 32'(s_err_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
